keccak_squeeze_param: RTL and testbench
=======================================

KECCAK_SQUEEZE_PARAM -- requirements
Module: keccak_squeeze_param

Interface
REQ-001 SHALL have parameter OW, default 32, output word width; legal values 32 and 64.
REQ-002 SHALL have parameter DW, default 11, width of digest-length input d.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 state_vld  input  1  one-cycle pulse: state_i holds a freshly permuted state.
REQ-006 state_i  input  1600  Keccak state, lane-string order (bit 0 = lane[0][0] bit 0).
REQ-007 cmode  input  3  0 SHA3-224, 1 SHA3-256, 2 SHA3-384, 3 SHA3-512, 4 SHAKE128, 5 SHAKE256, 6-7 illegal.
REQ-008 d  input  DW  SHAKE output length in bits; ignored for SHA3 modes.
REQ-009 o_ready  input  1  downstream accepts o_data this cycle.
REQ-010 o_data  output  OW  digest word.
REQ-011 o_valid  output  1  o_data valid.
REQ-012 o_last  output  1  final digest word; qualified by o_valid.
REQ-013 perm_req  output  1  one-cycle pulse requesting one more permutation (SHAKE squeeze).
REQ-014 busy  output  1  high whenever FSM is not IDLE.
REQ-015 err  output  1  one-cycle pulse on rejected start.

Function
REQ-016 SHALL implement FSM states IDLE, OUT, WAIT_PERM.
REQ-017 Digest length D: 224/256/384/512 for cmode 0-3; D = d for cmode 4-5.
REQ-018 Rate R: 1152/1088/832/576/1344/1088 bits for cmode 0-5.
REQ-019 IDLE + state_vld with legal cmode and D>0: register state_i, cmode, D; go OUT; o_valid high in the next cycle (latency 1).
REQ-020 IDLE + state_vld with cmode 6-7, or SHAKE with d=0: err pulse next cycle, stay IDLE, no o_valid.
REQ-021 Word k of a block SHALL be captured_state[k*OW +: OW], k from 0.
REQ-022 Transfer occurs on o_valid && o_ready; o_data/o_last SHALL hold stable while o_valid && !o_ready.
REQ-023 Remaining-bit counter (DW+1 bits) SHALL decrement by OW per transfer, saturating at 0.
REQ-024 Word where remaining <= OW: o_last=1; bits [OW-1:remaining] of o_data SHALL be zero.
REQ-025 Transfer of o_last word: return to IDLE; o_valid low next cycle.
REQ-026 Transfer of word k=R/OW-1 with remaining > OW: perm_req pulse next cycle, go WAIT_PERM, o_valid low.
REQ-027 WAIT_PERM + state_vld: capture new state, reset word index to 0, go OUT, o_valid next cycle; cmode/d not re-sampled.
REQ-028 state_vld in OUT SHALL be ignored (no capture, no err).
REQ-029 No cycle with o_valid high and busy low; busy SHALL drop in the cycle o_valid drops after the last word.
REQ-030 SHA3 modes never raise perm_req (D < R).
REQ-031 Back-to-back: state_vld in the same cycle as the returning-to-IDLE transfer SHALL be ignored; accepted from the next cycle.

Reset
REQ-032 rst SHALL asynchronously force IDLE; o_valid, o_last, perm_req, busy, err = 0; o_data = 0; counters = 0.
REQ-033 rst mid-OUT or mid-WAIT_PERM SHALL abort the digest with no further words or perm_req after rst deasserts.

Verification
REQ-034 OW=32, cmode=1, state_i[255:0]=incrementing bytes 00..1F -> 8 words, word0=0x03020100, o_last on word 7 = 0x1F1E1D1C, busy low after.
REQ-035 OW=32, cmode=1, o_ready low 3 cycles at word 2 -> o_data=0x0B0A0908 held 3 cycles, no word skipped or duplicated.
REQ-036 OW=64, cmode=4, d=1400 -> 21 words, perm_req pulse, second state_vld -> 1 word, bits [63:56] zero, o_last=1.
REQ-037 OW=64, cmode=0 -> 4 words, word 3 bits [63:32] zero, o_last=1, no perm_req.
REQ-038 rst pulse during word 3 of SHA3-512 -> o_valid=0 immediately, busy=0; next state_vld restarts from word 0.
REQ-039 cmode=6 state_vld, then cmode=5 d=0 state_vld -> err pulse each, o_valid never asserted, busy=0.

Source files
------------

// File: rtl/keccak_squeeze_param.sv
// Keccak squeeze stage: streams a SHA3/SHAKE digest out of a permuted 1600-bit state
// as OW-bit words, requesting extra permutations when a SHAKE output spans several blocks.
module keccak_squeeze_param #(
    parameter int OW = 32,
    parameter int DW = 11
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            state_vld,
    input  logic [1599:0]   state_i,
    input  logic [2:0]      cmode,
    input  logic [DW-1:0]   d,
    input  logic            o_ready,
    output logic [OW-1:0]   o_data,
    output logic            o_valid,
    output logic            o_last,
    output logic            perm_req,
    output logic            busy,
    output logic            err,
    output logic [1:0]      dbg_state
);

    localparam int RW = DW + 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        OUT       = 2'd1,
        WAIT_PERM = 2'd2
    } state_t;

    state_t          st;
    logic [1599:0]   blk_q;
    logic [2:0]      mode_q;
    logic [RW-1:0]   rem_q;
    logic [5:0]      idx_q;

    logic [RW-1:0]   dlen;
    logic            legal;
    logic [RW-1:0]   rem_next;

    // Number of OW-bit words in one rate block.
    function automatic logic [5:0] rate_words(input logic [2:0] m);
        case (m)
            3'd0:    rate_words = 6'(1152 / OW);
            3'd1:    rate_words = 6'(1088 / OW);
            3'd2:    rate_words = 6'(832 / OW);
            3'd3:    rate_words = 6'(576 / OW);
            3'd4:    rate_words = 6'(1344 / OW);
            3'd5:    rate_words = 6'(1088 / OW);
            default: rate_words = 6'd0;
        endcase
    endfunction

    function automatic logic [RW-1:0] digest_len(input logic [2:0] m, input logic [DW-1:0] dd);
        case (m)
            3'd0:      digest_len = RW'(224);
            3'd1:      digest_len = RW'(256);
            3'd2:      digest_len = RW'(384);
            3'd3:      digest_len = RW'(512);
            3'd4, 3'd5: digest_len = RW'(dd);
            default:   digest_len = '0;
        endcase
    endfunction

    // Word k of the block, with bits at and above the remaining length forced to zero.
    function automatic logic [OW-1:0] word_at(input logic [1599:0] s, input logic [5:0] k,
                                              input logic [RW-1:0] rem);
        logic [10:0]   base;
        logic [OW-1:0] w;
        base = 11'(k) * 11'(OW);
        w    = s[base +: OW];
        for (int i = 0; i < OW; i++) begin
            if (i >= 32'(rem)) w[i] = 1'b0;
        end
        return w;
    endfunction

    assign dlen      = digest_len(cmode, d);
    assign legal     = (cmode <= 3'd5) && (dlen != '0);
    assign rem_next  = (rem_q > RW'(OW)) ? (rem_q - RW'(OW)) : '0;
    assign dbg_state = st;

    // Handshake: a word moves when o_valid && o_ready at a rising edge; while o_valid is
    // high and o_ready low, o_data and o_last are held unchanged. o_valid never drops
    // without a transfer except on rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st       <= IDLE;
            blk_q    <= '0;
            mode_q   <= '0;
            rem_q    <= '0;
            idx_q    <= '0;
            o_data   <= '0;
            o_valid  <= 1'b0;
            o_last   <= 1'b0;
            perm_req <= 1'b0;
            busy     <= 1'b0;
            err      <= 1'b0;
        end else begin
            perm_req <= 1'b0;
            err      <= 1'b0;
            case (st)
                IDLE: begin
                    if (state_vld) begin
                        if (legal) begin
                            blk_q   <= state_i;
                            mode_q  <= cmode;
                            rem_q   <= dlen;
                            idx_q   <= '0;
                            o_data  <= word_at(state_i, 6'd0, dlen);
                            o_last  <= (dlen <= RW'(OW));
                            o_valid <= 1'b1;
                            busy    <= 1'b1;
                            st      <= OUT;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                OUT: begin
                    if (o_valid && o_ready) begin
                        rem_q <= rem_next;
                        if (o_last) begin
                            o_valid <= 1'b0;
                            o_last  <= 1'b0;
                            o_data  <= '0;
                            busy    <= 1'b0;
                            st      <= IDLE;
                        end else if (idx_q == rate_words(mode_q) - 6'd1) begin
                            // Block exhausted but digest not finished: ask for another permutation.
                            perm_req <= 1'b1;
                            o_valid  <= 1'b0;
                            o_data   <= '0;
                            st       <= WAIT_PERM;
                        end else begin
                            idx_q  <= idx_q + 6'd1;
                            o_data <= word_at(blk_q, idx_q + 6'd1, rem_next);
                            o_last <= (rem_next <= RW'(OW));
                        end
                    end
                end
                WAIT_PERM: begin
                    if (state_vld) begin
                        blk_q   <= state_i;
                        idx_q   <= '0;
                        o_data  <= word_at(state_i, 6'd0, rem_q);
                        o_last  <= (rem_q <= RW'(OW));
                        o_valid <= 1'b1;
                        st      <= OUT;
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_keccak_squeeze_param.sv
// Directed bench for keccak_squeeze_param: one OW=32 and one OW=64 instance, expected words
// queued at stimulus time and popped by per-instance monitors as words are transferred.
module tb_keccak_squeeze_param;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic            vld32, rdy32;
    logic [1599:0]   st32;
    logic [2:0]      cm32;
    logic [10:0]     d32;
    logic [31:0]     data32;
    logic            valid32, last32, preq32, busy32, err32;
    logic [1:0]      dbg32;

    logic            vld64, rdy64;
    logic [1599:0]   st64;
    logic [2:0]      cm64;
    logic [10:0]     d64;
    logic [63:0]     data64;
    logic            valid64, last64, preq64, busy64, err64;
    logic [1:0]      dbg64;

    keccak_squeeze_param #(.OW(32), .DW(11)) dut32 (
        .clk(clk), .rst(rst), .state_vld(vld32), .state_i(st32), .cmode(cm32), .d(d32),
        .o_ready(rdy32), .o_data(data32), .o_valid(valid32), .o_last(last32),
        .perm_req(preq32), .busy(busy32), .err(err32), .dbg_state(dbg32)
    );

    keccak_squeeze_param #(.OW(64), .DW(11)) dut64 (
        .clk(clk), .rst(rst), .state_vld(vld64), .state_i(st64), .cmode(cm64), .d(d64),
        .o_ready(rdy64), .o_data(data64), .o_valid(valid64), .o_last(last64),
        .perm_req(preq64), .busy(busy64), .err(err64), .dbg_state(dbg64)
    );

    int n_vec = 0;
    int n_err = 0;
    logic [32:0] exp32_q[$];
    logic [64:0] exp64_q[$];
    int xfer32 = 0, xfer64 = 0;
    int preq_cnt32 = 0, preq_cnt64 = 0;
    int err_cnt32 = 0, err_cnt64 = 0;

    task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1599:0] rand_state();
        logic [1599:0] s;
        for (int i = 0; i < 50; i++) s[i*32 +: 32] = $urandom();
        return s;
    endfunction

    // Expected words of one rate block: bits past the remaining length read as zero.
    task automatic push_block(input int ow, input logic [1599:0] s, inout int rem, input int rate);
        logic [63:0] w;
        for (int k = 0; k < rate / ow && rem > 0; k++) begin
            w = '0;
            for (int b = 0; b < ow; b++) if (b < rem) w[b] = s[k*ow + b];
            if (ow == 32) exp32_q.push_back({(rem <= 32), w[31:0]});
            else          exp64_q.push_back({(rem <= 64), w});
            rem = (rem > ow) ? rem - ow : 0;
        end
    endtask

    task automatic push_bytes_256();
        logic [31:0] w;
        for (int k = 0; k < 8; k++) begin
            w = {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
            exp32_q.push_back({(k == 7), w});
        end
    endtask

    task automatic pulse32(input logic [1599:0] s, input logic [2:0] m, input logic [10:0] dd);
        @(posedge clk); #1;
        vld32 = 1'b1; st32 = s; cm32 = m; d32 = dd;
        @(posedge clk); #1;
        vld32 = 1'b0;
    endtask

    task automatic pulse64(input logic [1599:0] s, input logic [2:0] m, input logic [10:0] dd);
        @(posedge clk); #1;
        vld64 = 1'b1; st64 = s; cm64 = m; d64 = dd;
        @(posedge clk); #1;
        vld64 = 1'b0;
    endtask

    task automatic wait_done32(input string tag);
        int n = 0;
        while ((busy32 || exp32_q.size() != 0) && n < 2000) begin @(negedge clk); n++; end
        check(tag, 65'(busy32), 65'(0));
        check({tag, "_queue"}, 65'(exp32_q.size()), 65'(0));
    endtask

    task automatic wait_done64(input string tag);
        int n = 0;
        while ((busy64 || exp64_q.size() != 0) && n < 2000) begin @(negedge clk); n++; end
        check(tag, 65'(busy64), 65'(0));
        check({tag, "_queue"}, 65'(exp64_q.size()), 65'(0));
    endtask

    initial begin : mon32
        logic [32:0] e, held;
        logic stall;
        stall = 1'b0;
        held  = '0;
        forever begin
            @(negedge clk);
            if (preq32) preq_cnt32++;
            if (err32) err_cnt32++;
            if (stall && valid32) check("hold32", 65'({last32, data32}), 65'(held));
            if (valid32) begin
                check("busy_with_valid32", 65'(busy32), 65'(1));
                if (rdy32) begin
                    xfer32++;
                    if (exp32_q.size() == 0) check("unexpected_word32", 65'(0), 65'(1));
                    else begin
                        e = exp32_q.pop_front();
                        check("word32", 65'({last32, data32}), 65'(e));
                    end
                end
            end
            stall = valid32 && !rdy32;
            held  = {last32, data32};
        end
    end

    initial begin : mon64
        logic [64:0] e, held;
        logic stall;
        stall = 1'b0;
        held  = '0;
        forever begin
            @(negedge clk);
            if (preq64) preq_cnt64++;
            if (err64) err_cnt64++;
            if (stall && valid64) check("hold64", {last64, data64}, held);
            if (valid64) begin
                check("busy_with_valid64", 65'(busy64), 65'(1));
                if (rdy64) begin
                    xfer64++;
                    if (exp64_q.size() == 0) check("unexpected_word64", 65'(0), 65'(1));
                    else begin
                        e = exp64_q.pop_front();
                        check("word64", {last64, data64}, e);
                    end
                end
            end
            stall = valid64 && !rdy64;
            held  = {last64, data64};
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [1599:0] s, s2;
        int rem, base, pb, ec, n;

        rst = 1'b1;
        vld32 = 1'b0; st32 = '0; cm32 = '0; d32 = '0; rdy32 = 1'b1;
        vld64 = 1'b0; st64 = '0; cm64 = '0; d64 = '0; rdy64 = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid32", 65'(valid32), 65'(0));
        check("rst_busy32",  65'(busy32),  65'(0));
        check("rst_data32",  65'(data32),  65'(0));
        check("rst_last32",  65'(last32),  65'(0));
        check("rst_preq32",  65'(preq32),  65'(0));
        check("rst_err32",   65'(err32),   65'(0));
        check("rst_dbg32",   65'(dbg32),   65'(0));
        check("rst_valid64", 65'(valid64), 65'(0));
        check("rst_busy64",  65'(busy64),  65'(0));
        check("rst_data64",  65'(data64),  65'(0));
        @(posedge clk); #1;
        rst = 1'b0;

        // SHA3-256 on OW=32: eight words of incrementing bytes.
        s = rand_state();
        for (int i = 0; i < 32; i++) s[i*8 +: 8] = 8'(i);
        push_bytes_256();
        pulse32(s, 3'd1, 11'd0);
        wait_done32("sha256_done");
        check("sha256_no_preq", 65'(preq_cnt32), 65'(0));

        // Same digest with o_ready held low for three cycles on word 2.
        push_bytes_256();
        base = xfer32;
        pulse32(s, 3'd1, 11'd0);
        n = 0;
        while (xfer32 < base + 2 && n < 100) begin @(posedge clk); n++; end
        #1 rdy32 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_data", 65'(data32), 65'(32'h0B0A0908));
            check("stall_valid", 65'(valid32), 65'(1));
            @(posedge clk);
        end
        #1 rdy32 = 1'b1;
        wait_done32("stall_done");

        // SHA3-224 with the next state_vld held across the final transfer.
        s  = rand_state();
        s2 = rand_state();
        rem = 224; push_block(32, s, rem, 1152);
        rem = 224; push_block(32, s2, rem, 1152);
        base = xfer32;
        pulse32(s, 3'd0, 11'd0);
        n = 0;
        while (xfer32 < base + 6 && n < 100) begin @(posedge clk); n++; end
        #1;
        vld32 = 1'b1; st32 = s2; cm32 = 3'd0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        vld32 = 1'b0;
        wait_done32("b2b_done");

        // SHAKE128 on OW=64 with d=1400: one full block, a permutation, one tail word.
        s  = rand_state();
        s2 = rand_state();
        rem = 1400; push_block(64, s, rem, 1344);
        pb = preq_cnt64;
        pulse64(s, 3'd4, 11'd1400);
        n = 0;
        while (preq_cnt64 == pb && n < 200) begin @(negedge clk); n++; end
        check("shake_preq", 65'(preq_cnt64 - pb), 65'(1));
        check("shake_wait_valid", 65'(valid64), 65'(0));
        check("shake_wait_busy", 65'(busy64), 65'(1));
        push_block(64, s2, rem, 1344);
        pulse64(s2, 3'd6, 11'd0);
        wait_done64("shake_done");
        check("shake_single_preq", 65'(preq_cnt64 - pb), 65'(1));
        check("shake_no_err", 65'(err_cnt64), 65'(0));

        // SHA3-224 on OW=64: four words, last one half zero, no permutation request.
        s = rand_state();
        rem = 224; push_block(64, s, rem, 1152);
        pb = preq_cnt64;
        pulse64(s, 3'd0, 11'd0);
        wait_done64("sha224_64_done");
        check("sha224_64_no_preq", 65'(preq_cnt64 - pb), 65'(0));

        // SHA3-512 aborted by rst on word 3, then restarted.
        s = rand_state();
        rem = 512; push_block(64, s, rem, 576);
        base = xfer64;
        pb = preq_cnt64;
        pulse64(s, 3'd3, 11'd0);
        n = 0;
        while (xfer64 < base + 3 && n < 100) begin @(posedge clk); n++; end
        #1 rst = 1'b1;
        #1;
        check("abort_valid", 65'(valid64), 65'(0));
        check("abort_busy", 65'(busy64), 65'(0));
        check("abort_last", 65'(last64), 65'(0));
        exp64_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_quiet", 65'(valid64), 65'(0));
        s = rand_state();
        rem = 512; push_block(64, s, rem, 576);
        pulse64(s, 3'd3, 11'd0);
        wait_done64("restart_done");
        check("restart_no_preq", 65'(preq_cnt64 - pb), 65'(0));

        // Rejected starts: illegal cmode, then SHAKE256 with d=0.
        ec = err_cnt32;
        pulse32(rand_state(), 3'd6, 11'd0);
        @(negedge clk);
        check("err_cmode6", 65'(err32), 65'(1));
        check("err_cmode6_valid", 65'(valid32), 65'(0));
        check("err_cmode6_busy", 65'(busy32), 65'(0));
        @(negedge clk);
        check("err_cmode6_pulse", 65'(err32), 65'(0));
        pulse32(rand_state(), 3'd5, 11'd0);
        @(negedge clk);
        check("err_d0", 65'(err32), 65'(1));
        check("err_d0_busy", 65'(busy32), 65'(0));
        @(negedge clk);
        check("err_d0_pulse", 65'(err32), 65'(0));
        check("err_count", 65'(err_cnt32 - ec), 65'(2));
        check("err_idle_valid", 65'(valid32), 65'(0));

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
